// File: rtl/menu_key_decoder.sv
// rtl/menu_key_decoder.sv - PS/2 set-2 make/break decoder driving the menu held-key code (optional MENU_KEY_TIMEOUT_EN)
module menu_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 650_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] key,
  output logic       key_strobe
);

  localparam logic [3:0] KEY_NONE = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_ESC  = 4'hF;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] key_q, key_d;
  logic       strobe_q, strobe_d;
  logic [3:0] mapped;
  logic       line_err;
  logic       prefix_timeout;

  function automatic logic [3:0] map_code(input logic [7:0] b);
    case (b)
      8'h16:   map_code = KEY_1;
      8'h1E:   map_code = KEY_2;
      8'h26:   map_code = KEY_3;
      8'h25:   map_code = KEY_4;
      8'h76:   map_code = KEY_ESC;
      default: map_code = KEY_NONE;
    endcase
  endfunction

  assign mapped   = map_code(rx_data);
  assign line_err = (rx_data == 8'h00) || (rx_data == 8'hFF);

`ifdef MENU_KEY_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Prefix age counter: runs only while a prefix is pending, restarts on every byte
  always_comb begin
    prefix_timeout = 1'b0;
    cnt_d          = '0;
    if (state_q != ST_IDLE && !rx_valid) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        prefix_timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prefix age counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic timeout_cycles_unused;
  assign timeout_cycles_unused = (TIMEOUT_CYCLES != 0);
  assign prefix_timeout = 1'b0;
`endif

  // Next-state decode: one byte per rx_valid cycle, a stale prefix falls back to IDLE
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (line_err) begin
            key_d = KEY_NONE;
          end else if (mapped != KEY_NONE && mapped != key_q) begin
            key_d    = mapped;
            strobe_d = 1'b1;
          end
        end
        ST_BRK: begin
          if (rx_data == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
            // Only a release of the currently held key clears it; stale breaks are ignored
            if (line_err || (mapped != KEY_NONE && mapped == key_q)) begin
              key_d = KEY_NONE;
            end
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
            if (line_err) begin
              key_d = KEY_NONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          if (line_err) begin
            key_d = KEY_NONE;
          end
        end
      endcase
    end else if (prefix_timeout) begin
      state_d = ST_IDLE;
    end
  end

  // Decoder state, held key and press strobe registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      key_q    <= KEY_NONE;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  assign key        = key_q;
  assign key_strobe = strobe_q;

endmodule
